// File: rtl/playfield_fetcher.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | playfield_fetcher: walks one scanline of tiles, fetches pattern rows and |
// | writes 2-bit pixels into the line buffer.            Rev 1.0             |
// +--------------------------------------------------------------------------+
module playfield_fetcher #(
  parameter int COLS = 32,
  parameter int ROWS = 30
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        line_go,
  input  logic [7:0]  row,
  input  logic        pf_bank,
  output logic [9:0]  pf_addr,
  input  logic [7:0]  pf_data,
  output logic [9:0]  rom_addr,
  input  logic [15:0] rom_data,
  output logic        lb_we,
  output logic [7:0]  lb_addr,
  output logic [1:0]  lb_data,
  output logic        busy,
  output logic        done
);

  localparam logic [5:0] c_ROWS_LIM = 6'(ROWS);
  localparam logic [4:0] c_LAST_COL = 5'(COLS - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    RAMW = 3'd2,
    ROM  = 3'd3,
    ROMW = 3'd4,
    PIX  = 3'd5
  } state_t;

  state_t      r_state;
  logic [4:0]  r_row_hi;
  logic [2:0]  r_fine;
  logic        r_bank;
  logic [4:0]  r_col;
  logic [2:0]  r_px;
  logic        r_hflip;
  logic [15:0] r_plane;
  logic [9:0]  r_pf_addr;
  logic [9:0]  r_rom_addr;
  logic        r_lb_we;
  logic [7:0]  r_lb_addr;
  logic [1:0]  r_lb_data;
  logic        r_busy;
  logic        r_done;

  logic        w_row_ok;
  logic [2:0]  w_px_nx;
  logic [2:0]  w_b_nx;
  logic [2:0]  w_b_first;

  assign w_row_ok  = ({1'b0, row[7:3]} < c_ROWS_LIM);
  assign w_px_nx   = r_px + 3'd1;
  // 7-px is the bitwise complement of a 3-bit px
  assign w_b_nx    = r_hflip ? w_px_nx : ~w_px_nx;
  assign w_b_first = r_hflip ? 3'd0 : 3'd7;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_state    <= IDLE;
      r_row_hi   <= '0;
      r_fine     <= '0;
      r_bank     <= 1'b0;
      r_col      <= '0;
      r_px       <= '0;
      r_hflip    <= 1'b0;
      r_plane    <= '0;
      r_pf_addr  <= '0;
      r_rom_addr <= '0;
      r_lb_we    <= 1'b0;
      r_lb_addr  <= '0;
      r_lb_data  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (line_go && w_row_ok) begin
            r_row_hi  <= row[7:3];
            r_fine    <= row[2:0];
            r_bank    <= pf_bank;
            r_col     <= '0;
            r_pf_addr <= {row[7:3], 5'd0};
            r_busy    <= 1'b1;
            r_state   <= ADDR;
          end
        end
        ADDR: r_state <= RAMW;
        RAMW: begin
          // Tile byte arrives this cycle; ROM address is formed straight from it
          r_hflip    <= pf_data[6];
          r_rom_addr <= {r_bank, pf_data[5:0], pf_data[7] ? ~r_fine : r_fine};
          r_state    <= ROM;
        end
        ROM: r_state <= ROMW;
        ROMW: begin
          r_plane   <= rom_data;
          r_px      <= '0;
          r_lb_we   <= 1'b1;
          r_lb_addr <= {r_col, 3'd0};
          r_lb_data <= {rom_data[{1'b1, w_b_first}], rom_data[{1'b0, w_b_first}]};
          r_state   <= PIX;
        end
        PIX: begin
          if (r_px == 3'd7) begin
            r_lb_we <= 1'b0;
            if (r_col == c_LAST_COL) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= IDLE;
            end else begin
              r_col     <= r_col + 5'd1;
              r_pf_addr <= {r_row_hi, r_col + 5'd1};
              r_state   <= ADDR;
            end
          end else begin
            r_px      <= w_px_nx;
            r_lb_addr <= {r_col, w_px_nx};
            r_lb_data <= {r_plane[{1'b1, w_b_nx}], r_plane[{1'b0, w_b_nx}]};
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign pf_addr  = r_pf_addr;
  assign rom_addr = r_rom_addr;
  assign lb_we    = r_lb_we;
  assign lb_addr  = r_lb_addr;
  assign lb_data  = r_lb_data;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_playfield_fetcher.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_playfield_fetcher: directed vector bench for playfield_fetcher.       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_playfield_fetcher;

  logic        clk;
  logic        rst_l;
  logic        line_go;
  logic [7:0]  row;
  logic        pf_bank;
  logic [9:0]  pf_addr;
  logic [7:0]  pf_data;
  logic [9:0]  rom_addr;
  logic [15:0] rom_data;
  logic        lb_we;
  logic [7:0]  lb_addr;
  logic [1:0]  lb_data;
  logic        busy;
  logic        done;

  logic [7:0]  ram [1024];
  logic [15:0] rom [1024];

  int n_pass = 0;
  int n_tot  = 0;

  playfield_fetcher #(.COLS(32), .ROWS(30)) dut (
    .clk      (clk),
    .rst_l    (rst_l),
    .line_go  (line_go),
    .row      (row),
    .pf_bank  (pf_bank),
    .pf_addr  (pf_addr),
    .pf_data  (pf_data),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .lb_we    (lb_we),
    .lb_addr  (lb_addr),
    .lb_data  (lb_data),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    pf_data  <= ram[pf_addr];
    rom_data <= rom[rom_addr];
  end

  // pat holds the 8 pixels of a tile, pixel 0 in bits [15:14]
  typedef struct {
    logic [7:0]  row;
    logic        bank;
    logic [7:0]  tile;
    logic [15:0] word;
    logic [9:0]  rom_a;
    logic [9:0]  last_pf;
    logic [15:0] pat;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string nm, input longint act, input longint exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic load(input vec_t v);
    for (int i = 0; i < 1024; i++) begin
      ram[i] = v.tile;
      rom[i] = 16'h0000;
    end
    rom[v.rom_a] = v.word;
  endtask

  task automatic run_line(input vec_t v, input int inj, input bit b2b);
    int ncyc;
    int cc, k, j;
    bit ew;
    int err_we, err_a, err_d, err_busy, err_done, err_pf, err_rom, nwr;
    longint last_pf;
    ncyc = b2b ? 780 : 400;
    err_we = 0; err_a = 0; err_d = 0; err_busy = 0; err_done = 0;
    err_pf = 0; err_rom = 0; nwr = 0; last_pf = -1;
    load(v);
    @(negedge clk);
    row = v.row; pf_bank = v.bank; line_go = 1'b1;
    @(negedge clk);
    line_go = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      cc = (b2b && c > 385) ? c - 385 : c;
      k  = cc - 5;
      j  = (k >= 0) ? k % 12 : 0;
      ew = (k >= 0) && (k < 384) && (j < 8);
      if (lb_we !== ew) err_we++;
      if (lb_we === 1'b1) nwr++;
      if (ew && lb_we === 1'b1) begin
        if (lb_addr !== 8'((k / 12) * 8 + j)) err_a++;
        if (lb_data !== v.pat[15 - 2*j -: 2]) err_d++;
      end
      if (busy !== ((cc >= 1) && (cc <= 384))) err_busy++;
      if (done !== (cc == 385)) err_done++;
      if (cc >= 1 && cc <= 384 && (cc - 1) % 12 == 0)
        if (pf_addr !== 10'(v.row[7:3] * 32 + (cc - 1) / 12)) err_pf++;
      if (cc >= 3 && cc <= 384 && (cc - 3) % 12 == 0)
        if (rom_addr !== v.rom_a) err_rom++;
      if (cc == 373) last_pf = longint'(pf_addr);
      line_go = (b2b && c == 385) || (c == inj);
      if (c == inj) row = 8'd16;
      @(negedge clk);
    end
    line_go = 1'b0;
    row = v.row;
    check("lb_we_timing", err_we, 0);
    check("lb_addr_seq", err_a, 0);
    check("pixel_data", err_d, 0);
    check("busy_window", err_busy, 0);
    check("done_pulse", err_done, 0);
    check("pf_addr_seq", err_pf, 0);
    check("rom_addr", err_rom, 0);
    check("write_count", nwr, b2b ? 512 : 256);
    check("last_pf_addr", last_pf, longint'(v.last_pf));
  endtask

  task automatic idle_watch(input string nm, input int n);
    int highs;
    highs = 0;
    for (int c = 0; c < n; c++) begin
      if (lb_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0) highs++;
      @(negedge clk);
    end
    check(nm, highs, 0);
  endtask

  initial begin
    //           row    bank  tile   word      rom_a    last_pf  pat
    vecs[0] = '{8'd0,   1'b0, 8'h05, 16'hA55A, 10'h028, 10'd31,  16'h9966};
    vecs[1] = '{8'd10,  1'b0, 8'hC5, 16'hA55A, 10'h02D, 10'd63,  16'h9966};
    vecs[2] = '{8'd10,  1'b0, 8'h45, 16'hF00C, 10'h02A, 10'd63,  16'h05AA};
    vecs[3] = '{8'd239, 1'b1, 8'h3F, 16'h8001, 10'h3FF, 10'd959, 16'h8001};
    vecs[4] = '{8'd3,   1'b0, 8'h85, 16'h00FF, 10'h02C, 10'd31,  16'h5555};

    rst_l = 1'b0; line_go = 1'b0; row = 8'd0; pf_bank = 1'b0;
    load(vecs[0]);
    repeat (3) @(negedge clk);
    check("reset_outputs", {pf_addr, rom_addr, lb_addr, lb_data, lb_we, busy, done}, 0);
    rst_l = 1'b1;

    for (int i = 0; i < 5; i++) run_line(vecs[i], 0, 1'b0);

    // ignored request mid-line
    run_line(vecs[2], 50, 1'b0);

    // out-of-range row is dropped
    @(negedge clk);
    row = 8'd240; line_go = 1'b1;
    @(negedge clk);
    line_go = 1'b0;
    idle_watch("oor_row_ignored", 400);

    // back-to-back lines
    run_line(vecs[0], 0, 1'b1);

    // reset mid-line
    load(vecs[3]);
    @(negedge clk);
    row = vecs[3].row; pf_bank = vecs[3].bank; line_go = 1'b1;
    @(negedge clk);
    line_go = 1'b0;
    repeat (99) @(negedge clk);
    check("pre_reset_busy", busy, 1);
    rst_l = 1'b0;
    #1;
    check("midline_reset_outputs",
          {pf_addr, rom_addr, lb_addr, lb_data, lb_we, busy, done}, 0);
    repeat (3) @(negedge clk);
    rst_l = 1'b1;
    idle_watch("post_reset_quiet", 400);
    run_line(vecs[3], 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
`default_nettype wire
